// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round controller and its helpers:
// FSM state encoding and the 16-bit Galois LFSR constants.
package whack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      UP   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Signal bundle between the round controller and the rest of the game
// (start/tick/buttons in, round-timer control and display outputs out).
interface mole_round_ctrl_if #(
   parameter int NUM_MOLES  = 4,
   parameter int TIMER_BITS = 6,
   parameter int SCORE_BITS = 8
);
   logic                  start;
   logic                  tick;
   logic [NUM_MOLES-1:0]  btn;
   logic [TIMER_BITS-1:0] timer_count;
   logic                  timer_srst;
   logic                  timer_en;
   logic [NUM_MOLES-1:0]  mole;
   logic [SCORE_BITS-1:0] score;
   logic                  hit;
   logic                  game_over;

   // Game side: drives the inputs, observes the controller outputs
   modport master (
      output start, tick, btn, timer_count,
      input  timer_srst, timer_en, mole, score, hit, game_over
   );

   // Controller side
   modport slave (
      input  start, tick, btn, timer_count,
      output timer_srst, timer_en, mole, score, hit, game_over
   );
endinterface

// File: rtl/mole_round_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock, reloads SEED on reset.
module lfsr16
   import whack_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        arst,
   output logic [15:0] q
);

   logic [15:0] r_q;

   // Shift right each cycle, folding the tap pattern in when bit 0 leaves
   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_q <= SEED;
      else      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
   end

   assign q = r_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer. Controls the countdown round timer, raises
// one pseudo-random mole at a time with gap/dwell timing, scores button hits
// and flags game over when the round timer reaches zero.
module mole_round_ctrl
   import whack_pkg::*;
#(
   parameter int          NUM_MOLES   = 4,
   parameter int          TIMER_BITS  = 6,
   parameter int          SCORE_BITS  = 8,
   parameter int          DWELL_TICKS = 750,
   parameter int          GAP_TICKS   = 250,
   parameter int          TICK_BITS   = 10,
   parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
   input  logic             clk,
   input  logic             arst,
   mole_round_ctrl_if.slave bus
);

   localparam int                   IDX_W      = $clog2(NUM_MOLES);
   localparam logic [TICK_BITS-1:0] GAP_LAST   = TICK_BITS'(GAP_TICKS - 1);
   localparam logic [TICK_BITS-1:0] DWELL_LAST = TICK_BITS'(DWELL_TICKS - 1);

   state_t                r_state,     w_state_nxt;
   logic [NUM_MOLES-1:0]  r_mole,      w_mole_nxt;
   logic [SCORE_BITS-1:0] r_score,     w_score_nxt;
   logic                  r_hit,       w_hit_nxt;
   logic                  r_game_over, w_game_over_nxt;
   logic [TICK_BITS-1:0]  r_cnt,       w_cnt_nxt;
   logic [IDX_W-1:0]      r_prev_idx,  w_prev_idx_nxt;

   logic [15:0]           w_lfsr;
   logic [IDX_W-1:0]      w_cand;
   logic [IDX_W-1:0]      w_sel;
   logic [NUM_MOLES-1:0]  w_onehot;
   logic                  w_match;
   logic                  w_timer_end;
   logic                  w_unused_lfsr;

   // Score saturates at all-ones instead of wrapping
   function automatic logic [SCORE_BITS-1:0] sat_inc(input logic [SCORE_BITS-1:0] s);
      return (&s) ? s : s + SCORE_BITS'(1);
   endfunction

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .arst (arst),
      .q    (w_lfsr)
   );

   // Low LFSR bits pick the mole; bump by one on a repeat so the same mole
   // never shows twice in a row (wraps naturally, NUM_MOLES is a power of 2)
   assign w_cand        = w_lfsr[IDX_W-1:0];
   assign w_sel         = (w_cand == r_prev_idx) ? w_cand + IDX_W'(1) : w_cand;
   assign w_onehot      = NUM_MOLES'(1) << w_sel;
   assign w_unused_lfsr = ^w_lfsr[15:IDX_W];

   assign w_match     = |(bus.btn & r_mole);
   assign w_timer_end = (bus.timer_count == '0);

   // Next-state and registered-output decisions
   always_comb begin
      w_state_nxt     = r_state;
      w_mole_nxt      = r_mole;
      w_score_nxt     = r_score;
      w_hit_nxt       = 1'b0;
      w_game_over_nxt = r_game_over;
      w_cnt_nxt       = r_cnt;
      w_prev_idx_nxt  = r_prev_idx;

      unique case (r_state)
         IDLE: begin
            w_mole_nxt      = '0;
            w_game_over_nxt = 1'b0;
            if (bus.start) begin
               w_state_nxt = GAP;
               w_score_nxt = '0;
               w_cnt_nxt   = '0;
            end
         end

         GAP: begin
            w_mole_nxt = '0;
            if (bus.tick) begin
               if (r_cnt == GAP_LAST) begin
                  w_state_nxt    = UP;
                  w_mole_nxt     = w_onehot;
                  w_prev_idx_nxt = w_sel;
                  w_cnt_nxt      = '0;
               end else begin
                  w_cnt_nxt = r_cnt + TICK_BITS'(1);
               end
            end
         end

         UP: begin
            if (w_match) begin
               w_hit_nxt   = 1'b1;
               w_score_nxt = sat_inc(r_score);
               w_mole_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = GAP;
            end else if (bus.tick) begin
               if (r_cnt == DWELL_LAST) begin
                  w_mole_nxt  = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = GAP;
               end else begin
                  w_cnt_nxt = r_cnt + TICK_BITS'(1);
               end
            end
         end

         DONE: begin
            w_mole_nxt      = '0;
            w_game_over_nxt = 1'b1;
            if (bus.start) begin
               w_state_nxt     = GAP;
               w_score_nxt     = '0;
               w_cnt_nxt       = '0;
               w_game_over_nxt = 1'b0;
            end
         end

         default: w_state_nxt = IDLE;
      endcase

      // End of round overrides any gap/dwell move; a same-cycle hit above
      // has already been scored
      if ((r_state == GAP || r_state == UP) && w_timer_end) begin
         w_state_nxt     = DONE;
         w_mole_nxt      = '0;
         w_game_over_nxt = 1'b1;
      end
   end

   // State and registered outputs; reset aborts any round in progress
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= IDLE;
         r_mole      <= '0;
         r_score     <= '0;
         r_hit       <= 1'b0;
         r_game_over <= 1'b0;
         r_cnt       <= '0;
         r_prev_idx  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mole      <= w_mole_nxt;
         r_score     <= w_score_nxt;
         r_hit       <= w_hit_nxt;
         r_game_over <= w_game_over_nxt;
         r_cnt       <= w_cnt_nxt;
         r_prev_idx  <= w_prev_idx_nxt;
      end
   end

   // Round-timer control is combinational so the counter clears/steps in
   // step with this FSM
   assign bus.timer_srst = (r_state == IDLE) |
                           (bus.start & ((r_state == IDLE) | (r_state == DONE)));
   assign bus.timer_en   = bus.tick & ((r_state == GAP) | (r_state == UP));

   assign bus.mole      = r_mole;
   assign bus.score     = r_score;
   assign bus.hit       = r_hit;
   assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: NUM_MOLES=4, GAP_TICKS=2,
// DWELL_TICKS=4, SCORE_BITS=2, tick held high every cycle.
module tb_mole_round_ctrl;

   logic clk  = 1'b0;
   logic arst = 1'b1;

   mole_round_ctrl_if #(.NUM_MOLES(4), .TIMER_BITS(6), .SCORE_BITS(2)) bus ();

   mole_round_ctrl #(
      .NUM_MOLES   (4),
      .TIMER_BITS  (6),
      .SCORE_BITS  (2),
      .DWELL_TICKS (4),
      .GAP_TICKS   (2),
      .TICK_BITS   (3),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference LFSR; m_lfsr_prev is the value the DUT saw on the last edge
   logic [15:0] m_lfsr, m_lfsr_prev;
   int          exp_prev = 0;
   logic [3:0]  first_m1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         m_lfsr      <= 16'hACE1;
         m_lfsr_prev <= 16'hACE1;
      end else begin
         m_lfsr_prev <= m_lfsr;
         m_lfsr      <= lfsr_next(m_lfsr);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic expect_mole(input string tag, input logic [3:0] m, input logic [15:0] snap);
      int         cand;
      logic [3:0] e;
      cand = int'(snap[1:0]);
      if (cand == exp_prev) cand = (cand + 1) % 4;
      e = 4'(1 << cand);
      check_eq(tag, 32'(m), 32'(e));
      exp_prev = cand;
   endtask

   task automatic wait_rise(output int gap, output logic [3:0] m, output logic [15:0] snap);
      gap = 0;
      while (bus.mole == 4'd0 && gap < 60) begin
         gap++;
         @(negedge clk);
      end
      m    = bus.mole;
      snap = m_lfsr_prev;
   endtask

   task automatic wait_fall();
      int n;
      n = 0;
      while (bus.mole != 4'd0 && n < 60) begin
         n++;
         @(negedge clk);
      end
      check_eq("fall_tmo", 32'(n < 60), 32'd1);
   endtask

   task automatic measure(output int gap, output int up, output logic [3:0] m, output logic [15:0] snap);
      wait_rise(gap, m, snap);
      up = 0;
      while (m != 4'd0 && bus.mole == m && up < 60) begin
         up++;
         @(negedge clk);
      end
   endtask

   task automatic start_round();
      bus.start = 1'b1;
      #1;
      check_eq("srst_on_start", 32'(bus.timer_srst), 32'd1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_hit(input logic [1:0] exp_score);
      int          g;
      logic [3:0]  m;
      logic [15:0] s;
      wait_rise(g, m, s);
      expect_mole("hit_mole_idx", m, s);
      bus.btn = m;
      @(negedge clk);
      bus.btn = 4'd0;
      check_eq("hit_pulse", 32'(bus.hit), 32'd1);
      check_eq("hit_score", 32'(bus.score), 32'(exp_score));
      check_eq("hit_mole_clr", 32'(bus.mole), 32'd0);
      @(negedge clk);
      check_eq("hit_one_cycle", 32'(bus.hit), 32'd0);
   endtask

   task automatic idle_checks();
      check_eq("idle_mole", 32'(bus.mole), 32'd0);
      check_eq("idle_score", 32'(bus.score), 32'd0);
      check_eq("idle_go", 32'(bus.game_over), 32'd0);
      check_eq("idle_srst", 32'(bus.timer_srst), 32'd1);
      check_eq("idle_en", 32'(bus.timer_en), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          gap, up;
      logic [3:0]  m, prev_m;
      logic [15:0] snap;

      bus.start       = 1'b0;
      bus.tick        = 1'b1;
      bus.btn         = 4'd0;
      bus.timer_count = 6'd10;

      // Reset state
      repeat (3) @(negedge clk);
      idle_checks();
      check_eq("rst_hit", 32'(bus.hit), 32'd0);
      arst = 1'b0;
      repeat (4) @(negedge clk);
      idle_checks();

      // Free-running moles with no buttons
      start_round();
      check_eq("gap_en", 32'(bus.timer_en), 32'd1);
      check_eq("gap_srst", 32'(bus.timer_srst), 32'd0);
      prev_m = 4'd0;
      for (int i = 0; i < 5; i++) begin
         measure(gap, up, m, snap);
         if (i == 0) first_m1 = m;
         check_eq("gap_len", 32'(gap), 32'd2);
         check_eq("up_len", 32'(up), 32'd4);
         expect_mole("mole_idx", m, snap);
         check_eq("mole_differs", 32'(m != prev_m), 32'd1);
         check_eq("miss_score", 32'(bus.score), 32'd0);
         prev_m = m;
      end

      // Matching hit, then a non-matching button
      do_hit(2'd1);
      wait_rise(gap, m, snap);
      expect_mole("miss_mole_idx", m, snap);
      bus.btn = ~m;
      @(negedge clk);
      bus.btn = 4'd0;
      check_eq("wrong_btn_score", 32'(bus.score), 32'd1);
      check_eq("wrong_btn_hit", 32'(bus.hit), 32'd0);
      check_eq("wrong_btn_mole", 32'(bus.mole), 32'(m));
      wait_fall();

      // Round ends together with a valid hit
      wait_rise(gap, m, snap);
      expect_mole("end_mole_idx", m, snap);
      bus.btn         = m;
      bus.timer_count = 6'd0;
      @(negedge clk);
      bus.btn         = 4'd0;
      bus.timer_count = 6'd10;
      check_eq("end_hit", 32'(bus.hit), 32'd1);
      check_eq("end_score", 32'(bus.score), 32'd2);
      check_eq("end_go", 32'(bus.game_over), 32'd1);
      check_eq("end_mole", 32'(bus.mole), 32'd0);
      check_eq("end_en", 32'(bus.timer_en), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("done_hold_go", 32'(bus.game_over), 32'd1);
      check_eq("done_hold_score", 32'(bus.score), 32'd2);
      check_eq("done_hit", 32'(bus.hit), 32'd0);
      check_eq("done_en", 32'(bus.timer_en), 32'd0);
      check_eq("done_srst", 32'(bus.timer_srst), 32'd0);

      // Restart from DONE, then saturate the 2-bit score
      start_round();
      check_eq("restart_score", 32'(bus.score), 32'd0);
      check_eq("restart_go", 32'(bus.game_over), 32'd0);
      check_eq("restart_en", 32'(bus.timer_en), 32'd1);
      do_hit(2'd1);
      do_hit(2'd2);
      do_hit(2'd3);
      do_hit(2'd3);

      // Asynchronous reset while a mole is up
      wait_rise(gap, m, snap);
      expect_mole("pre_rst_mole", m, snap);
      #2 arst = 1'b1;
      #1;
      check_eq("arst_mole", 32'(bus.mole), 32'd0);
      check_eq("arst_score", 32'(bus.score), 32'd0);
      check_eq("arst_hit", 32'(bus.hit), 32'd0);
      check_eq("arst_go", 32'(bus.game_over), 32'd0);
      check_eq("arst_en", 32'(bus.timer_en), 32'd0);
      check_eq("arst_srst", 32'(bus.timer_srst), 32'd1);
      exp_prev = 0;
      repeat (3) @(negedge clk);
      arst = 1'b0;
      repeat (4) @(negedge clk);
      idle_checks();
      start_round();
      measure(gap, up, m, snap);
      check_eq("replay_first_mole", 32'(m), 32'(first_m1));
      expect_mole("replay_mole_idx", m, snap);
      check_eq("replay_gap", 32'(gap), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
